// File: rtl/ahb_arbiter_slave_5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_slave_5_pkg
// Description : Shared AHB encodings and arbiter state type for the
//               per-slave arbiters.
//               HTRANS_*      : AHB htrans encodings
//               HBURST_SINGLE : AHB single-beat burst encoding
//               arb_state_e   : arbiter ownership state
//               inc_wrap()    : modulo-n increment of a channel index
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_arbiter_slave_5_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Next channel index after idx, wrapping at n.
  function automatic int inc_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arbiter_slave_5_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_slave_5_rr_pick
// Description : Combinational round-robin priority picker. Returns the first
//               set request bit found searching upward from start_i, with
//               wrap-around.
// Ports       : req_i   [N-1:0]      request vector
//               start_i [IDX_W-1:0]  index searched first
//               grant_o [N-1:0]      one-hot winner (zero when no request)
//               valid_o              a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_slave_5_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;
  logic [2*N-1:0] gnt_dbl;
  logic [IDX_W:0] back_off;

  // Rotate so start_i lands on bit 0, take the lowest set bit, rotate back.
  assign req_dbl  = {req_i, req_i};
  assign req_rot  = req_dbl[start_i +: N];
  assign gnt_dbl  = {gnt_rot, gnt_rot};
  assign back_off = (IDX_W+1)'(N) - {1'b0, start_i};
  assign grant_o  = gnt_dbl[back_off +: N];
  assign valid_o  = |req_i;

  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_rot = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        gnt_rot[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter_slave_5.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_slave_5
// Description : Per-slave AHB round-robin arbiter for slave_5. Holds the
//               grant across bursts and locked sequences and only moves it
//               on cycles accepted by the slave.
// Ports       : hclk, hreset      clock, synchronous active-high reset
//               req, hmastlock    per-master request / lock
//               htrans_sel        htrans of the granted master
//               hburst_sel        hburst of the granted master
//               hready_in         slave HREADYOUT (address phase accepted)
//               sel, sel_data     one-hot address / data phase owner
//               hmaster, owned    encoded owner index, owner present
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_slave_5
  import ahb_arbiter_slave_5_pkg::*;
#(
  parameter int CHANNEL_NUM = 4,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [CHANNEL_NUM-1:0] req,
  input  logic [CHANNEL_NUM-1:0] hmastlock,
  input  logic [1:0]             htrans_sel,
  input  logic [2:0]             hburst_sel,
  input  logic                   hready_in,
  output logic [CHANNEL_NUM-1:0] sel,
  output logic [CHANNEL_NUM-1:0] sel_data,
  output logic [IDX_W-1:0]       hmaster,
  output logic                   owned
);

  arb_state_e             state_q, state_d;
  logic [CHANNEL_NUM-1:0] sel_q, sel_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]       owner_idx;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       pick_start;
  logic [CHANNEL_NUM-1:0] pick_grant;
  logic                   pick_valid;
  logic                   owner_lock;
  logic                   owner_req;
  logic                   handover;

  always_comb begin
    owner_idx = '0;
    win_idx   = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (sel_q[i])      owner_idx = IDX_W'(i);
      if (pick_grant[i]) win_idx   = IDX_W'(i);
    end
  end

  // While owned, the search starts just past the owner so the owner itself
  // is considered last and only keeps the bus when nobody else asks.
  assign pick_start = (state_q == ARB_OWNED)
                    ? IDX_W'(inc_wrap(int'(owner_idx), CHANNEL_NUM))
                    : rr_ptr_q;

  ahb_arbiter_slave_5_rr_pick #(
    .N     (CHANNEL_NUM),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .start_i (pick_start),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  assign owner_lock = |(hmastlock & sel_q);
  assign owner_req  = |(req & sel_q);
  // Burst beats (SEQ/BUSY, or NONSEQ of a multi-beat burst) keep ownership.
  assign handover   = !owner_lock &&
                      (!owner_req || (htrans_sel == HTRANS_IDLE) ||
                       ((htrans_sel == HTRANS_NONSEQ) && (hburst_sel == HBURST_SINGLE)));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    sel_data_d = sel_data_q;
    rr_ptr_d   = rr_ptr_q;
    if (hready_in) begin
      // Only NONSEQ/SEQ transfers advance into a data phase.
      sel_data_d = (owned && htrans_sel[1]) ? sel_q : '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            sel_d   = pick_grant;
            state_d = ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          if (handover) begin
            if (pick_valid) begin
              sel_d    = pick_grant;
              rr_ptr_d = IDX_W'(inc_wrap(int'(win_idx), CHANNEL_NUM));
            end else begin
              sel_d   = '0;
              state_d = ARB_IDLE;
            end
          end
        end
        default: begin
          sel_d   = '0;
          state_d = ARB_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= ARB_IDLE;
      sel_q      <= '0;
      sel_data_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sel_data_q <= sel_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign sel      = sel_q;
  assign sel_data = sel_data_q;
  assign hmaster  = owner_idx;
  assign owned    = |sel_q;

  a_sel_onehot0 : assert property (@(posedge hclk) disable iff (hreset) $onehot0(sel_q));

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter_slave_5.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_arbiter_slave_5
// Description : Self-checking bench for ahb_arbiter_slave_5: directed
//               scenarios followed by random traffic, all compared against a
//               behavioural ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter_slave_5;

  localparam int N = 4;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [N-1:0] req;
  logic [N-1:0] hmastlock;
  logic [1:0]   htrans_sel;
  logic [2:0]   hburst_sel;
  logic         hready_in;
  logic [N-1:0] sel;
  logic [N-1:0] sel_data;
  logic [1:0]   hmaster;
  logic         owned;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: index of address-phase owner, data-phase owner (-1 = none), pointer.
  int m_owner = -1;
  int m_data  = -1;
  int m_ptr   = 0;

  ahb_arbiter_slave_5 #(.CHANNEL_NUM(N)) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .req        (req),
    .hmastlock  (hmastlock),
    .htrans_sel (htrans_sel),
    .hburst_sel (hburst_sel),
    .hready_in  (hready_in),
    .sel        (sel),
    .sel_data   (sel_data),
    .hmaster    (hmaster),
    .owned      (owned)
  );

  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int idx);
    for (int k = 0; k < N; k++) if (k == idx) return v[k];
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) if (k == idx) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int first_req(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (bit_of(r, (start + k) % N)) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  nd;
    int  w;
    logic ho;
    if (hreset) begin
      m_owner = -1;
      m_data  = -1;
      m_ptr   = 0;
      return;
    end
    if (!hready_in) return;
    nd = (m_owner >= 0 && htrans_sel[1]) ? m_owner : -1;
    if (m_owner < 0) begin
      m_owner = first_req(req, m_ptr);
    end else begin
      ho = !bit_of(hmastlock, m_owner) &&
           (!bit_of(req, m_owner) || htrans_sel == 2'b00 ||
            (htrans_sel == 2'b10 && hburst_sel == 3'b000));
      if (ho) begin
        w = first_req(req, (m_owner + 1) % N);
        m_owner = w;
        if (w >= 0) m_ptr = (w + 1) % N;
      end
    end
    m_data = nd;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [1:0] t,
                      input logic [2:0] b, input logic rdy, input logic rst);
    req        = r;
    hmastlock  = l;
    htrans_sel = t;
    hburst_sel = b;
    hready_in  = rdy;
    hreset     = rst;
    @(posedge hclk);
    model_step();
    #1;
    check_eq("sel", 32'(sel), 32'(onehot(m_owner)));
    check_eq("sel_data", 32'(sel_data), 32'(onehot(m_data)));
    check_eq("hmaster", 32'(hmaster), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check_eq("owned", 32'(owned), (m_owner >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    // Reset, then no requests.
    step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
      check_eq("idle_sel", 32'(sel), 32'h0);
      check_eq("idle_sel_data", 32'(sel_data), 32'h0);
      check_eq("idle_owned", 32'(owned), 32'h0);
    end

    // IDLE grant from pointer 0, then a SINGLE NONSEQ hands over.
    step(4'b0110, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    check_eq("rr_first_sel", 32'(sel), 32'h2);
    check_eq("rr_first_hmaster", 32'(hmaster), 32'h1);
    step(4'b0110, 4'b0000, 2'b10, 3'b000, 1'b1, 1'b0);
    check_eq("rr_single_sel", 32'(sel), 32'h4);

    // INCR4 by master 0 keeps the bus; IDLE afterwards passes it to 3.
    step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b1);
    step(4'b1001, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    check_eq("burst_grant", 32'(sel), 32'h1);
    step(4'b1001, 4'b0000, 2'b10, 3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
      check_eq("burst_hold", 32'(sel), 32'h1);
    end
    step(4'b1001, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    check_eq("burst_handover", 32'(sel), 32'h8);

    // Wait states freeze everything.
    step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b1);
    step(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 2'b10, 3'b011, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 4'b0000, 2'b11, 3'b011, 1'b0, 1'b0);
      check_eq("wait_sel", 32'(sel), 32'h4);
      check_eq("wait_sel_data", 32'(sel_data), 32'h4);
    end
    step(4'b0101, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    check_eq("wait_release_sel", 32'(sel), 32'h1);
    check_eq("wait_release_data", 32'(sel_data), 32'h0);

    // Locked owner keeps the bus through IDLE.
    step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b1);
    step(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(4'b1010, 4'b0010, 2'b00, 3'b000, 1'b1, 1'b0);
      check_eq("lock_hold", 32'(sel), 32'h2);
    end
    step(4'b1010, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    check_eq("lock_release", 32'(sel), 32'h8);

    // Reset mid-burst clears the pointer as well.
    step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b1);
    step(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    step(4'b0110, 4'b0000, 2'b10, 3'b000, 1'b1, 1'b0);
    step(4'b0110, 4'b0000, 2'b10, 3'b011, 1'b1, 1'b0);
    check_eq("pre_rst_sel", 32'(sel), 32'h4);
    step(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b1);
    check_eq("mid_rst_sel", 32'(sel), 32'h0);
    check_eq("mid_rst_data", 32'(sel_data), 32'h0);
    step(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    check_eq("post_rst_ptr", 32'(sel), 32'h1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      logic [1:0]   t;
      logic [2:0]   b;
      logic         rdy;
      logic         rst;
      r   = 4'($urandom);
      l   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      t   = (m_owner < 0) ? 2'b00 : 2'($urandom);
      case ($urandom_range(0, 2))
        0:       b = 3'b000;
        1:       b = 3'b001;
        default: b = 3'b011;
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step(r, l, t, b, rdy, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
